// File: rtl/pipe_pkg.sv
// Shared pipeline types and sizes for the IF/ID/EXE/WB datapath.
package pipe_pkg;
   localparam int DATA_W = 32;
   localparam int NREG   = 32;
   localparam int ADDR_W = 5;

   typedef logic [ADDR_W-1:0] reg_idx_t;
   typedef logic [DATA_W-1:0] word_t;
   typedef logic [1:0]        sb_cnt_t;

   localparam sb_cnt_t SB_MAX = 2'd3;
endpackage

// File: rtl/wb_regfile_stage_if.sv
// Issue/EXE/decode-read/writeback signal bundle of the writeback stage.
interface wb_regfile_stage_if;
   import pipe_pkg::*;

   logic     issue_valid;
   reg_idx_t issue_rd;
   logic     issue_wen;
   logic     exe_valid;
   logic     exe_wen;
   reg_idx_t exe_rd;
   word_t    exe_aluout;
   reg_idx_t rs1_addr;
   reg_idx_t rs2_addr;
   logic     rs1_use;
   logic     rs2_use;
   word_t    rs1_data;
   word_t    rs2_data;
   logic     stall;
   word_t    aluout_EXE_WB;
   logic     wb_valid;
   reg_idx_t wb_rd;

   modport master (
      output issue_valid, issue_rd, issue_wen,
      output exe_valid, exe_wen, exe_rd, exe_aluout,
      output rs1_addr, rs2_addr, rs1_use, rs2_use,
      input  rs1_data, rs2_data, stall, aluout_EXE_WB, wb_valid, wb_rd
   );

   modport slave (
      input  issue_valid, issue_rd, issue_wen,
      input  exe_valid, exe_wen, exe_rd, exe_aluout,
      input  rs1_addr, rs2_addr, rs1_use, rs2_use,
      output rs1_data, rs2_data, stall, aluout_EXE_WB, wb_valid, wb_rd
   );
endinterface

// File: rtl/scoreboard_ctr_array.sv
// Per-register in-flight write counters and RAW hazard detection for decode.
module scoreboard_ctr_array
   import pipe_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     inc_i,
   input  reg_idx_t inc_rd_i,
   input  logic     dec_i,
   input  reg_idx_t dec_rd_i,
   input  reg_idx_t rs1_addr_i,
   input  logic     rs1_use_i,
   input  reg_idx_t rs2_addr_i,
   input  logic     rs2_use_i,
   output logic     stall_o
);

   logic [NREG-1:0] busy;

   for (genvar r = 0; r < NREG; r++) begin : g_reg
      sb_cnt_t cnt_q, cnt_d;
      logic    inc_hit, dec_hit;

      assign inc_hit = inc_i && (inc_rd_i == reg_idx_t'(r));
      assign dec_hit = dec_i && (dec_rd_i == reg_idx_t'(r));

      always_comb begin
         cnt_d = cnt_q;
         if (inc_hit && !dec_hit && cnt_q != SB_MAX)
            cnt_d = cnt_q + 2'd1;
         else if (dec_hit && !inc_hit && cnt_q != 2'd0)
            cnt_d = cnt_q - 2'd1;
      end

      always_ff @(posedge clk) begin
         if (!rst) cnt_q <= '0;
         else      cnt_q <= cnt_d;
      end

      // A write already in WB retires this cycle, so it no longer blocks a reader.
      assign busy[r] = cnt_q > {1'b0, dec_hit};

`ifndef SYNTHESIS
      ap_no_overflow: assert property (@(posedge clk) disable iff (!rst)
         !(inc_hit && !dec_hit && cnt_q == SB_MAX));
`endif
   end

   assign stall_o = (rs1_use_i && rs1_addr_i != '0 && busy[rs1_addr_i]) ||
                    (rs2_use_i && rs2_addr_i != '0 && busy[rs2_addr_i]);

endmodule

// File: rtl/wb_regfile_stage.sv
// Writeback stage: EXE/WB register, 32x32 register file with WB->ID bypass, hazard stall.
module wb_regfile_stage
   import pipe_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   wb_regfile_stage_if.slave  bus
);

   word_t    regs_q [NREG];
   word_t    aluout_q, aluout_d;
   logic     wb_valid_q, wb_valid_d;
   reg_idx_t wb_rd_q;
   logic     issue_inc;

   assign aluout_d   = bus.exe_valid ? bus.exe_aluout : aluout_q;
   assign wb_valid_d = bus.exe_valid && bus.exe_wen && (bus.exe_rd != '0);
   assign issue_inc  = bus.issue_valid && bus.issue_wen && (bus.issue_rd != '0);

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
         aluout_q   <= '0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= '0;
      end else begin
         aluout_q   <= aluout_d;
         wb_valid_q <= wb_valid_d;
         wb_rd_q    <= bus.exe_rd;
         if (wb_valid_q) regs_q[wb_rd_q] <= aluout_q;
      end
   end

   function automatic word_t rd_port(reg_idx_t a);
      if (a == '0)                       return '0;
      if (wb_valid_q && wb_rd_q == a)    return aluout_q;
      return regs_q[a];
   endfunction

   assign bus.rs1_data      = rd_port(bus.rs1_addr);
   assign bus.rs2_data      = rd_port(bus.rs2_addr);
   assign bus.aluout_EXE_WB = aluout_q;
   assign bus.wb_valid      = wb_valid_q;
   assign bus.wb_rd         = wb_rd_q;

   scoreboard_ctr_array u_sb (
      .clk        (clk),
      .rst        (rst),
      .inc_i      (issue_inc),
      .inc_rd_i   (bus.issue_rd),
      .dec_i      (wb_valid_q),
      .dec_rd_i   (wb_rd_q),
      .rs1_addr_i (bus.rs1_addr),
      .rs1_use_i  (bus.rs1_use),
      .rs2_addr_i (bus.rs2_addr),
      .rs2_use_i  (bus.rs2_use),
      .stall_o    (bus.stall)
   );

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Scoreboard bench for wb_regfile_stage: directed vectors, decoupled monitor.
module tb_wb_regfile_stage;

   typedef enum int {K_ALU, K_WBV, K_WBRD, K_RS1, K_RS2, K_STALL} kind_e;
   typedef struct {
      int          cyc;
      kind_e       kind;
      logic [31:0] exp;
      string       name;
   } chk_t;
   typedef struct {
      int          cyc;
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   chk_t chk_q[$];
   wb_t  wb_q[$];

   wb_regfile_stage_if bus();

   wb_regfile_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   function automatic logic [31:0] sample(kind_e k);
      case (k)
         K_ALU:   return bus.aluout_EXE_WB;
         K_WBV:   return {31'b0, bus.wb_valid};
         K_WBRD:  return {27'b0, bus.wb_rd};
         K_RS1:   return bus.rs1_data;
         K_RS2:   return bus.rs2_data;
         default: return {31'b0, bus.stall};
      endcase
   endfunction

   // Monitor: compares everything due this cycle, and every committing write.
   initial begin
      chk_t        c;
      wb_t         w;
      logic [31:0] act;
      forever begin
         @(negedge clk);
         while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
            c = chk_q.pop_front();
            act = sample(c.kind);
            n_chk++;
            if (c.cyc != cyc || act !== c.exp) begin
               n_fail++;
               $display("FAIL %s (cycle %0d): got %h, expected %h", c.name, c.cyc, act, c.exp);
            end
         end
         if (bus.wb_valid === 1'b1) begin
            n_chk++;
            if (wb_q.size() == 0) begin
               n_fail++;
               $display("FAIL wb_unexpected (cycle %0d): got rd=%0d data=%h, expected no write",
                        cyc, bus.wb_rd, bus.aluout_EXE_WB);
            end else begin
               w = wb_q.pop_front();
               if (w.cyc != cyc || bus.wb_rd !== w.rd || bus.aluout_EXE_WB !== w.data) begin
                  n_fail++;
                  $display("FAIL wb_commit (cycle %0d): got rd=%0d data=%h, expected rd=%0d data=%h at cycle %0d",
                           cyc, bus.wb_rd, bus.aluout_EXE_WB, w.rd, w.data, w.cyc);
               end
            end
         end else if (wb_q.size() > 0 && wb_q[0].cyc <= cyc) begin
            w = wb_q.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL wb_missing (cycle %0d): got wb_valid=%b, expected rd=%0d data=%h",
                     cyc, bus.wb_valid, w.rd, w.data);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.issue_valid = 1'b0; bus.issue_rd = '0; bus.issue_wen = 1'b0;
      bus.exe_valid   = 1'b0; bus.exe_wen  = 1'b0; bus.exe_rd = '0; bus.exe_aluout = '0;
      bus.rs1_addr    = '0;   bus.rs2_addr = '0;
      bus.rs1_use     = 1'b0; bus.rs2_use  = 1'b0;
   endtask

   task automatic expect_v(kind_e k, logic [31:0] v, string n);
      chk_t c;
      c.cyc = cyc; c.kind = k; c.exp = v; c.name = n;
      chk_q.push_back(c);
   endtask

   task automatic exe(logic [4:0] rd, logic [31:0] v, logic wen);
      wb_t w;
      bus.exe_valid = 1'b1; bus.exe_wen = wen; bus.exe_rd = rd; bus.exe_aluout = v;
      if (wen && rd != 5'd0 && rst) begin
         w.cyc = cyc + 1; w.rd = rd; w.data = v;
         wb_q.push_back(w);
      end
   endtask

   task automatic issue(logic [4:0] rd, logic wen);
      bus.issue_valid = 1'b1; bus.issue_rd = rd; bus.issue_wen = wen;
   endtask

   task automatic rd1(logic [4:0] a, logic use_it);
      bus.rs1_addr = a; bus.rs1_use = use_it;
   endtask

   task automatic rd2(logic [4:0] a, logic use_it);
      bus.rs2_addr = a; bus.rs2_use = use_it;
   endtask

   initial begin
      // Reset held two edges with a write presented in EXE.
      idle();
      exe(5'd4, 32'hDEAD_BEEF, 1'b1);
      tick(); tick();
      rst = 1'b1;
      for (int a = 0; a < 32; a++) begin
         idle();
         rd1(a[4:0], 1'b1);
         expect_v(K_RS1, 32'h0, "reset_rd");
         expect_v(K_STALL, 32'h0, "reset_stall");
         if (a == 0) begin
            expect_v(K_ALU, 32'h0, "reset_alu");
            expect_v(K_WBV, 32'h0, "reset_wbv");
         end
         tick();
      end

      // Basic writeback, bypass in WB cycle, then array read.
      idle(); exe(5'd5, 32'h0000_00AB, 1'b1); tick();
      idle(); rd1(5'd5, 1'b1);
      expect_v(K_ALU, 32'hAB, "wb_alu"); expect_v(K_WBV, 32'h1, "wb_valid");
      expect_v(K_WBRD, 32'd5, "wb_rd");  expect_v(K_RS1, 32'hAB, "bypass_rs1");
      tick();
      idle(); rd1(5'd5, 1'b1);
      expect_v(K_RS1, 32'hAB, "array_rd5"); expect_v(K_WBV, 32'h0, "wbv_clear");
      expect_v(K_ALU, 32'hAB, "alu_hold");
      tick();

      // Bypass on rs2.
      idle(); exe(5'd7, 32'h0000_1234, 1'b1); tick();
      idle(); rd2(5'd7, 1'b1);
      expect_v(K_RS2, 32'h1234, "bypass_rs2"); expect_v(K_STALL, 32'h0, "bypass_nostall");
      tick();

      // EXE result without a register write; then exe_valid=0 holds aluout.
      idle(); exe(5'd6, 32'h66, 1'b0); tick();
      idle(); rd1(5'd6, 1'b1);
      expect_v(K_WBV, 32'h0, "nowen_wbv"); expect_v(K_ALU, 32'h66, "nowen_alu");
      expect_v(K_RS1, 32'h0, "nowen_reg");
      tick();
      idle(); bus.exe_wen = 1'b1; bus.exe_rd = 5'd6; bus.exe_aluout = 32'h77; tick();
      idle(); expect_v(K_WBV, 32'h0, "novalid_wbv"); expect_v(K_ALU, 32'h66, "novalid_hold");
      tick();

      // Issue without write-enable does not mark the register busy.
      idle(); issue(5'd13, 1'b0); tick();
      idle(); rd1(5'd13, 1'b1); expect_v(K_STALL, 32'h0, "issue_nowen"); tick();

      // RAW hazard on rd=3.
      idle(); issue(5'd3, 1'b1); expect_v(K_STALL, 32'h0, "raw_issue"); tick();
      idle(); exe(5'd3, 32'h3333, 1'b1); rd1(5'd3, 1'b1);
      expect_v(K_STALL, 32'h1, "raw_exe_stall"); tick();
      idle(); rd1(5'd3, 1'b1); rd2(5'd3, 1'b1);
      expect_v(K_STALL, 32'h0, "raw_wb_stall");
      expect_v(K_RS1, 32'h3333, "raw_wb_rs1"); expect_v(K_RS2, 32'h3333, "raw_wb_rs2");
      tick();
      idle(); rd1(5'd3, 1'b1);
      expect_v(K_STALL, 32'h0, "raw_done_stall"); expect_v(K_RS1, 32'h3333, "raw_array");
      tick();

      // Busy register hidden when the reader does not use it.
      idle(); issue(5'd12, 1'b1); tick();
      idle(); exe(5'd12, 32'hC, 1'b1); rd1(5'd12, 1'b0); rd2(5'd12, 1'b0);
      expect_v(K_STALL, 32'h0, "use_gate"); tick();
      idle(); tick();

      // Back-to-back writes to rd=9.
      idle(); issue(5'd9, 1'b1); tick();
      idle(); issue(5'd9, 1'b1); exe(5'd9, 32'h11, 1'b1); rd2(5'd9, 1'b0);
      expect_v(K_STALL, 32'h0, "b2b_issue2"); tick();
      idle(); exe(5'd9, 32'h22, 1'b1); rd2(5'd9, 1'b1);
      expect_v(K_STALL, 32'h1, "b2b_cnt2_stall"); expect_v(K_RS2, 32'h11, "b2b_byp1");
      tick();
      idle(); rd2(5'd9, 1'b1);
      expect_v(K_STALL, 32'h0, "b2b_wb2_stall"); expect_v(K_RS2, 32'h22, "b2b_byp2");
      tick();
      idle(); rd1(5'd9, 1'b1);
      expect_v(K_STALL, 32'h0, "b2b_final_stall"); expect_v(K_RS1, 32'h22, "b2b_final");
      tick();

      // r0 is never written, never scoreboarded, never stalls.
      idle(); exe(5'd0, 32'hFFFF_FFFF, 1'b1); issue(5'd0, 1'b1); rd1(5'd0, 1'b1);
      expect_v(K_STALL, 32'h0, "r0_stall"); expect_v(K_RS1, 32'h0, "r0_rs1");
      tick();
      idle(); rd1(5'd0, 1'b1); rd2(5'd0, 1'b1);
      expect_v(K_WBV, 32'h0, "r0_wbv"); expect_v(K_ALU, 32'hFFFF_FFFF, "r0_alu");
      expect_v(K_RS2, 32'h0, "r0_rs2"); expect_v(K_STALL, 32'h0, "r0_stall2");
      tick();

      // Reset while a write sits in WB and a counter is pending.
      idle(); exe(5'd10, 32'h1010, 1'b1); issue(5'd11, 1'b1); tick();
      idle(); rst = 1'b0; expect_v(K_WBV, 32'h1, "pre_rst_wbv"); tick();
      rst = 1'b1;
      idle(); rd1(5'd10, 1'b1); rd2(5'd11, 1'b1);
      expect_v(K_RS1, 32'h0, "rst_discard"); expect_v(K_STALL, 32'h0, "rst_sb_clear");
      expect_v(K_ALU, 32'h0, "rst_alu");     expect_v(K_WBV, 32'h0, "rst_wbv");
      tick();
      idle(); rd1(5'd3, 1'b1); rd2(5'd9, 1'b1);
      expect_v(K_RS1, 32'h0, "rst_reg3"); expect_v(K_RS2, 32'h0, "rst_reg9");
      tick();

      idle(); tick(); tick();
      if (chk_q.size() != 0) begin
         n_fail++;
         $display("FAIL chk_drain: got %0d pending checks, expected 0", chk_q.size());
      end
      if (wb_q.size() != 0) begin
         n_fail++;
         $display("FAIL wb_drain: got %0d pending writes, expected 0", wb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
